// File: rtl/latch_bank.sv
// ============================================================================
//  Module      : latch_bank
//  Description : Synchronous register bank that stands in for arrays of
//                high-active transparent latch cells. DEPTH words of W bits,
//                per-word valid bits, registered read port, bulk clear of the
//                valid bits, and a one-cycle collision pulse.
//  Optional    : LATCH_BYPASS_EN -- when defined, a same-cycle same-address
//                write is forwarded to the read port (latch transparency).
//                When undefined, collision reads return the old contents.
//  Ports       : ck_i    clock, rising edge
//                rst_i   synchronous active-high reset
//                clr_i   bulk clear of all valid bits
//                we_i    write enable, wa_i write address, d_i write data
//                re_i    read enable,  ra_i read address
//                q_o     registered read data (0 for invalid words)
//                qv_o    registered valid flag of the word read
//                coll_o  one-cycle pulse on same-address read/write
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module latch_bank #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          ck_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          we_i,
  input  logic [AW-1:0] wa_i,
  input  logic [W-1:0]  d_i,
  input  logic          re_i,
  input  logic [AW-1:0] ra_i,
  output logic [W-1:0]  q_o,
  output logic          qv_o,
  output logic          coll_o
);

  // One extra bit so DEPTH itself is representable when it is a power of two.
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic [W-1:0]     q_q;
  logic [W-1:0]     q_d;
  logic             qv_q;
  logic             qv_d;
  logic             coll_q;
  logic             coll_d;

  logic             wr_ok_w;
  logic             rd_ok_w;
  logic             hit_w;

  // Out-of-range addresses are ignored rather than aliased onto real words.
  assign wr_ok_w = we_i && ({1'b0, wa_i} < DEPTH_C);
  assign rd_ok_w = ({1'b0, ra_i} < DEPTH_C);
  assign hit_w   = re_i && wr_ok_w && (ra_i == wa_i);

  // Data array carries no reset; only the valid bits decide what is visible.
  // A write presented during reset is discarded.
  always_ff @(posedge ck_i) begin
    if (!rst_i && wr_ok_w) begin
      mem_q[wa_i] <= d_i;
    end
  end

  // Clear first, then the write sets its own bit so a concurrent write wins.
  always_comb begin
    vld_d = clr_i ? '0 : vld_q;
    if (wr_ok_w) begin
      vld_d[wa_i] = 1'b1;
    end
  end

  // Read samples pre-edge state, so without forwarding a colliding read
  // naturally returns the old word (read-before-write) and pre-clear valid.
  always_comb begin
    q_d    = q_q;
    qv_d   = qv_q;
    coll_d = hit_w;
    if (re_i) begin
      if (rd_ok_w && vld_q[ra_i]) begin
        q_d  = mem_q[ra_i];
        qv_d = 1'b1;
      end else begin
        q_d  = '0;
        qv_d = 1'b0;
      end
`ifdef LATCH_BYPASS_EN
      if (hit_w) begin
        q_d  = d_i;
        qv_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge ck_i) begin
    if (rst_i) begin
      vld_q  <= '0;
      q_q    <= '0;
      qv_q   <= 1'b0;
      coll_q <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      q_q    <= q_d;
      qv_q   <= qv_d;
      coll_q <= coll_d;
    end
  end

  assign q_o    = q_q;
  assign qv_o   = qv_q;
  assign coll_o = coll_q;

endmodule

`default_nettype wire

// File: tb/tb_latch_bank.sv
// ============================================================================
//  Module      : tb_latch_bank
//  Description : Self-checking bench for latch_bank. Instance A uses the
//                default DEPTH=4, instance B uses DEPTH=5 (AW=3) to reach
//                out-of-range addresses. Directed vector table, a hand
//                sequence for out-of-range access, then random traffic
//                checked against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_latch_bank;

`ifdef LATCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic ck = 1'b0;
  always #5 ck = ~ck;

  // Instance A: DEPTH=4
  logic       a_rst, a_clr, a_we, a_re;
  logic [1:0] a_wa, a_ra;
  logic [7:0] a_d, a_q;
  logic       a_qv, a_coll;

  // Instance B: DEPTH=5
  logic       b_rst, b_clr, b_we, b_re;
  logic [2:0] b_wa, b_ra;
  logic [7:0] b_d, b_q;
  logic       b_qv, b_coll;

  latch_bank #(.W(8), .DEPTH(4)) u_a (
    .ck_i(ck), .rst_i(a_rst), .clr_i(a_clr), .we_i(a_we), .wa_i(a_wa),
    .d_i(a_d), .re_i(a_re), .ra_i(a_ra), .q_o(a_q), .qv_o(a_qv),
    .coll_o(a_coll)
  );

  latch_bank #(.W(8), .DEPTH(5)) u_b (
    .ck_i(ck), .rst_i(b_rst), .clr_i(b_clr), .we_i(b_we), .wa_i(b_wa),
    .d_i(b_d), .re_i(b_re), .ra_i(b_ra), .q_o(b_q), .qv_o(b_qv),
    .coll_o(b_coll)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       rst, clr, we;
    logic [1:0] wa;
    logic [7:0] d;
    logic       re;
    logic [1:0] ra;
    logic [7:0] eq;
    logic       eqv, ecoll;
  } vec_t;

  function automatic vec_t mk(logic rst, logic clr, logic we, logic [1:0] wa,
                              logic [7:0] d, logic re, logic [1:0] ra,
                              logic [7:0] eq, logic eqv, logic ecoll);
    vec_t v;
    v.rst = rst; v.clr = clr; v.we = we; v.wa = wa; v.d = d;
    v.re = re; v.ra = ra; v.eq = eq; v.eqv = eqv; v.ecoll = ecoll;
    return v;
  endfunction

  localparam int NV = 27;
  vec_t tbl [NV];

  // Behavioural model, one slot per instance
  logic [7:0] m_mem [2][32];
  bit         m_vld [2][32];
  logic [7:0] m_q   [2];
  bit         m_qv  [2];
  bit         m_coll[2];

  task automatic model_step(input int k, input int dp, input bit rst, input bit clr,
                            input bit we, input int wa, input logic [7:0] d,
                            input bit re, input int ra);
    bit wr_in;
    if (rst) begin
      for (int i = 0; i < 32; i++) m_vld[k][i] = 0;
      m_q[k] = 8'h00; m_qv[k] = 0; m_coll[k] = 0;
      return;
    end
    wr_in = we && (wa < dp);
    m_coll[k] = re && wr_in && (wa == ra);
    if (re) begin
      if (ra < dp && m_vld[k][ra]) begin
        m_q[k] = m_mem[k][ra]; m_qv[k] = 1;
      end else begin
        m_q[k] = 8'h00; m_qv[k] = 0;
      end
      if (m_coll[k] && BYP) begin
        m_q[k] = d; m_qv[k] = 1;
      end
    end
    if (clr) for (int i = 0; i < 32; i++) m_vld[k][i] = 0;
    if (wr_in) begin
      m_mem[k][wa] = d; m_vld[k][wa] = 1;
    end
  endtask

  task automatic stepb(input logic clr, input logic we, input logic [2:0] wa,
                       input logic [7:0] d, input logic re, input logic [2:0] ra);
    b_rst = 0; b_clr = clr; b_we = we; b_wa = wa; b_d = d; b_re = re; b_ra = ra;
    @(posedge ck); #1;
  endtask

  initial begin
    logic [7:0] coll_q;
    coll_q = BYP ? 8'h22 : 8'h11;

    //            rst clr we wa  d      re ra  eq     eqv ecoll
    tbl[0]  = mk(1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 8'h00, 1, 1, 8'h00, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 8'h00, 1, 2, 8'h00, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 8'h00, 1, 3, 8'h00, 0, 0);
    tbl[6]  = mk(0, 0, 1, 2, 8'hA5, 0, 0, 8'h00, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0, 8'h00, 1, 2, 8'hA5, 1, 0);
    tbl[8]  = mk(0, 0, 0, 0, 8'h00, 0, 0, 8'hA5, 1, 0);
    tbl[9]  = mk(0, 0, 0, 0, 8'h00, 0, 1, 8'hA5, 1, 0);
    tbl[10] = mk(0, 0, 0, 0, 8'h00, 0, 3, 8'hA5, 1, 0);
    tbl[11] = mk(0, 0, 1, 1, 8'h11, 0, 0, 8'hA5, 1, 0);
    tbl[12] = mk(0, 0, 1, 1, 8'h22, 1, 1, coll_q, 1, 1);
    tbl[13] = mk(0, 0, 0, 0, 8'h00, 0, 0, coll_q, 1, 0);
    tbl[14] = mk(0, 0, 1, 0, 8'h01, 0, 0, coll_q, 1, 0);
    tbl[15] = mk(0, 0, 1, 3, 8'h03, 0, 0, coll_q, 1, 0);
    tbl[16] = mk(0, 1, 1, 3, 8'h5A, 0, 0, coll_q, 1, 0);
    tbl[17] = mk(0, 0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0);
    tbl[18] = mk(0, 0, 0, 0, 8'h00, 1, 1, 8'h00, 0, 0);
    tbl[19] = mk(0, 0, 0, 0, 8'h00, 1, 2, 8'h00, 0, 0);
    tbl[20] = mk(0, 0, 0, 0, 8'h00, 1, 3, 8'h5A, 1, 0);
    tbl[21] = mk(1, 0, 1, 0, 8'h33, 1, 3, 8'h00, 0, 0);
    tbl[22] = mk(0, 0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0);
    tbl[23] = mk(0, 0, 0, 0, 8'h00, 1, 3, 8'h00, 0, 0);
    tbl[24] = mk(0, 0, 1, 1, 8'h77, 0, 0, 8'h00, 0, 0);
    tbl[25] = mk(0, 1, 0, 0, 8'h00, 1, 1, 8'h77, 1, 0);
    tbl[26] = mk(0, 0, 0, 0, 8'h00, 1, 1, 8'h00, 0, 0);

    a_rst = 1; a_clr = 0; a_we = 0; a_wa = 0; a_d = 0; a_re = 0; a_ra = 0;
    b_rst = 1; b_clr = 0; b_we = 0; b_wa = 0; b_d = 0; b_re = 0; b_ra = 0;

    // Directed vectors on instance A
    for (int i = 0; i < NV; i++) begin
      a_rst = tbl[i].rst; a_clr = tbl[i].clr; a_we = tbl[i].we; a_wa = tbl[i].wa;
      a_d = tbl[i].d; a_re = tbl[i].re; a_ra = tbl[i].ra;
      @(posedge ck); #1;
      check($sformatf("vec%0d.q", i), a_q, tbl[i].eq);
      check($sformatf("vec%0d.qv", i), {7'd0, a_qv}, {7'd0, tbl[i].eqv});
      check($sformatf("vec%0d.coll", i), {7'd0, a_coll}, {7'd0, tbl[i].ecoll});
    end
    a_rst = 0; a_clr = 0; a_we = 0; a_re = 0;

    // Out-of-range sequence on instance B (held in reset so far)
    stepb(0, 1, 3'd4, 8'h44, 0, 3'd0);
    check("oor.reset_q", b_q, 8'h00);
    check("oor.reset_qv", {7'd0, b_qv}, 8'h00);
    stepb(0, 1, 3'd6, 8'hFF, 1, 3'd6);
    check("oor.rd6_q", b_q, 8'h00);
    check("oor.rd6_qv", {7'd0, b_qv}, 8'h00);
    check("oor.rd6_coll", {7'd0, b_coll}, 8'h00);
    stepb(0, 0, 3'd0, 8'h00, 1, 3'd4);
    check("oor.rd4_q", b_q, 8'h44);
    check("oor.rd4_qv", {7'd0, b_qv}, 8'h01);
    stepb(0, 0, 3'd0, 8'h00, 0, 3'd0);
    check("oor.hold_q", b_q, 8'h44);
    for (int r = 0; r < 8; r++) begin
      if (r == 4) continue;
      stepb(0, 0, 3'd0, 8'h00, 1, 3'(r));
      check($sformatf("oor.rd%0d_q", r), b_q, 8'h00);
      check($sformatf("oor.rd%0d_qv", r), {7'd0, b_qv}, 8'h00);
    end

    // Random traffic on both instances against the model
    a_rst = 1; b_rst = 1;
    a_clr = 0; b_clr = 0; a_we = 0; b_we = 0; a_re = 0; b_re = 0;
    @(posedge ck); #1;
    model_step(0, 4, 1, 0, 0, 0, 8'h00, 0, 0);
    model_step(1, 5, 1, 0, 0, 0, 8'h00, 0, 0);
    for (int n = 0; n < 2000; n++) begin
      a_rst = ($urandom_range(0, 63) == 0);
      a_clr = ($urandom_range(0, 9) == 0);
      a_we  = 1'($urandom);
      a_re  = 1'($urandom);
      a_wa  = 2'($urandom_range(0, 3));
      a_ra  = ($urandom_range(0, 2) == 0) ? a_wa : 2'($urandom_range(0, 3));
      a_d   = 8'($urandom);
      b_rst = ($urandom_range(0, 63) == 0);
      b_clr = ($urandom_range(0, 9) == 0);
      b_we  = 1'($urandom);
      b_re  = 1'($urandom);
      b_wa  = 3'($urandom_range(0, 7));
      b_ra  = ($urandom_range(0, 2) == 0) ? b_wa : 3'($urandom_range(0, 7));
      b_d   = 8'($urandom);
      @(posedge ck); #1;
      model_step(0, 4, a_rst, a_clr, a_we, int'(a_wa), a_d, a_re, int'(a_ra));
      model_step(1, 5, b_rst, b_clr, b_we, int'(b_wa), b_d, b_re, int'(b_ra));
      check($sformatf("rnd%0d.a_q", n), a_q, m_q[0]);
      check($sformatf("rnd%0d.a_qv", n), {7'd0, a_qv}, {7'd0, m_qv[0]});
      check($sformatf("rnd%0d.a_coll", n), {7'd0, a_coll}, {7'd0, m_coll[0]});
      check($sformatf("rnd%0d.b_q", n), b_q, m_q[1]);
      check($sformatf("rnd%0d.b_qv", n), {7'd0, b_qv}, {7'd0, m_qv[1]});
      check($sformatf("rnd%0d.b_coll", n), {7'd0, b_coll}, {7'd0, m_coll[1]});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/latch_bank.md
# latch_bank

Parametrised, fully synchronous register bank that replaces arrays of discrete high-active transparent latch cells in our standard-cell datapaths. It stores DEPTH words of W bits with per-word valid tracking, a registered read port, a bulk-clear input and optional write-to-read forwarding that reproduces latch transparency in a clocked design. It sits between a producer issuing addressed writes and a consumer issuing addressed reads, both in the CK domain.

## Interface
- W, default 8: data width in bits, 1 to 64.
- DEPTH, default 4: number of words, 2 to 32; need not be a power of two.
- AW, default $clog2(DEPTH): address width; derived, not overridden.

- CK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, synchronous and active-high.
- CLR  in  1  bulk clear of all valid bits; synchronous.
- WE  in  1  write enable.
- WA  in  AW  write address.
- D  in  W  write data.
- RE  in  1  read enable.
- RA  in  AW  read address.
- Q  out  W  registered read data.
- QV  out  1  registered valid flag of the word read.
- COLL  out  1  one-cycle pulse on a same-address read/write collision.

## Operation
- Storage: DEPTH x W data array, not reset, plus a DEPTH-bit valid vector VLD.
- Write: WE=1 and WA<DEPTH at an edge: word[WA]<=D and VLD[WA]<=1. WA>=DEPTH: write dropped, no state change.
- Read: RE=1 at an edge: Q<=VLD[RA] ? word[RA] : 0 and QV<=VLD[RA]. Invalid words always read as Q=0. RA>=DEPTH: Q<=0, QV<=0.
- RE=0: Q and QV hold their previous values.
- CLR=1: all VLD bits cleared at the edge. CLR and WE in the same cycle: all VLD cleared except VLD[WA], which is set (write wins). Data array is untouched by CLR.
- A read in the same cycle as CLR samples the pre-clear VLD/data, except that a same-address write follows the collision rule below.
- Collision: RE=1, WE=1, RA==WA<DEPTH in the same cycle:
  - With forwarding: Q<=D, QV<=1 (see Configuration).
  - Without forwarding: Q and QV return the pre-write word and valid flag.
  - COLL<=1 for exactly one cycle in both cases; otherwise COLL<=0.
- RST=1: VLD<=0, Q<=0, QV<=0, COLL<=0. RST overrides WE, RE and CLR in the same cycle. A write issued in the reset cycle is lost.

## Timing
- Write to storage: visible to a read issued in the next cycle (1-cycle write-to-read without forwarding).
- Read latency: 1 cycle. RE/RA sampled at edge n, Q/QV valid after edge n.
- COLL is asserted in the same cycle that Q shows the collision result.
- No combinational path from any input to Q, QV or COLL.
- Reset values: Q=0, QV=0, COLL=0. After RST deassertion, the first read returns Q=0, QV=0 for every address until that word is written.

## Configuration
- LATCH_BYPASS_EN defined: same-cycle same-address write data is forwarded to Q, matching the transparent-while-enabled behaviour of the latch cells being replaced.
- LATCH_BYPASS_EN undefined: no forwarding mux. Collision reads return old contents (read-before-write), and COLL still pulses.
- All other behaviour is identical in both builds.

## Test plan
- Reset then read all addresses: RST=1 for 2 cycles, then RE with RA=0..3 -> Q=0x00, QV=0 each cycle; COLL=0.
- Write then read: WE, WA=2, D=0xA5; next cycle RE, RA=2 -> one cycle later Q=0xA5, QV=1; then RE=0 for 3 cycles -> Q holds 0xA5.
- Collision: word 1 holds 0x11; same cycle WE, WA=1, D=0x22, RE, RA=1 -> with LATCH_BYPASS_EN Q=0x22, QV=1; without it Q=0x11, QV=1; COLL=1 for one cycle in both builds.
- Clear with write: words 0..3 valid; CLR=1 with WE, WA=3, D=0x5A -> subsequent reads give QV=0, Q=0 for addresses 0..2, and Q=0x5A, QV=1 for address 3.
- Out-of-range with DEPTH=5 (AW=3): WE, WA=6, D=0xFF; RE, RA=6 -> Q=0, QV=0, and no valid word changes.
- Reset mid-operation: WE, WA=0, D=0x33 in the same cycle as RST=1 -> Q=0, QV=0, COLL=0; a later read of address 0 returns QV=0.
